// File: rtl/seq_mod_pkg.sv
// ---------------------------------------------------------------------------
// seq_mod_pkg
// Shared types and helpers for the serial mod-N check stream.
//   state_t      : generator FSM states (IDLE, DATA, TRAIL)
//   clog2()      : ceiling log2, used for counter and residue widths
//   res_step()   : one residue step, (2*res + bit) mod m
//   trailer_for(): trailer that makes the frame divisible by m
// ---------------------------------------------------------------------------
package seq_mod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Appending one bit to a binary number doubles it and adds the bit.
  function automatic int res_step(input int res, input logic b, input int m);
    return (2 * res + int'(b)) % m;
  endfunction

  // Shifting the payload left by trail_w bits multiplies its residue by
  // 2^trail_w; the trailer is whatever brings that back to 0 mod m.
  function automatic int trailer_for(input int res, input int trail_w, input int m);
    int rs;
    rs = (res << trail_w) % m;
    return (m - rs) % m;
  endfunction

endpackage

// File: rtl/seq_mod_residue.sv
// ---------------------------------------------------------------------------
// seq_mod_residue
// Running residue (mod MOD) of a serial MSB-first bit stream.
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   clr      in   1      restart the residue at 0 (wins over en)
//   en       in   1      fold bit_in into the residue this cycle
//   bit_in   in   1      next stream bit
//   res_out  out  RES_W  residue of all bits folded in since the last clr
// ---------------------------------------------------------------------------
module seq_mod_residue
  import seq_mod_pkg::*;
#(
  parameter int MOD   = 3,
  parameter int RES_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [RES_W-1:0] res_out
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out <= '0;
    end else if (clr) begin
      res_out <= '0;
    end else if (en) begin
      res_out <= RES_W'(res_step(int'(res_out), bit_in, MOD));
    end
  end

endmodule

// File: rtl/seq_mod3_generator.sv
// ---------------------------------------------------------------------------
// seq_mod3_generator
// Serialises a DATA_W-bit payload MSB-first and appends a TRAIL_W-bit
// trailer so the whole frame, read as one unsigned number, is divisible
// by MOD. Feeds seq_mod3_detector.
//
// Optional build macro: SEQ_MOD3_GEN_SELFCHK_EN adds output chk_err, which
// pulses the cycle after frame_end if the emitted frame is not 0 mod MOD.
//
// Ports:
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   in_valid     in   1        payload word offered
//   in_ready     out  1        word can be accepted this cycle (combinational)
//   in_data      in   DATA_W   payload word
//   data         out  1        serial frame bit (registered)
//   data_vld     out  1        data carries a frame bit
//   frame_start  out  1        first bit (payload MSB) of a frame
//   frame_end    out  1        last trailer bit of a frame
//   chk_err      out  1        self-check error pulse (macro builds only)
// ---------------------------------------------------------------------------
module seq_mod3_generator
  import seq_mod_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MOD     = 3,
  parameter int TRAIL_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              data,
  output logic              data_vld,
  output logic              frame_start,
  output logic              frame_end
`ifdef SEQ_MOD3_GEN_SELFCHK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int FRAME_LEN = DATA_W + TRAIL_W;
  localparam int CNT_W     = clog2(FRAME_LEN);
  localparam int RES_W     = clog2(MOD);

  // The counter names the frame bit currently on 'data'; DATA and TRAIL
  // share it so TRAIL simply continues from DATA_W.
  localparam logic [CNT_W-1:0] LAST_DATA   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] FIRST_TRAIL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_TRAIL  = CNT_W'(FRAME_LEN - 1);

  if (TRAIL_W != clog2(MOD)) begin : g_bad_trail_w
    $error("seq_mod3_generator: TRAIL_W must equal clog2(MOD)");
  end
  if (MOD < 2) begin : g_bad_mod
    $error("seq_mod3_generator: MOD must be >= 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("seq_mod3_generator: DATA_W must be >= 1");
  end

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [TRAIL_W-1:0]  trl_q, trl_d;
  logic                data_d, vld_d, fs_d, fe_d;
  logic                accept;
  logic [RES_W-1:0]    res_q;
  logic [TRAIL_W-1:0]  trailer;

  assign in_ready = (state_q == IDLE) ||
                    ((state_q == TRAIL) && (cnt_q == LAST_TRAIL));
  assign accept   = in_valid && in_ready;

  // Residue of the payload bits already shown on 'data'. It lags by one
  // bit, so the bit on 'data' in the last DATA cycle is folded in here.
  seq_mod_residue #(
    .MOD   (MOD),
    .RES_W (RES_W)
  ) u_res (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (state_q == DATA),
    .bit_in  (data),
    .res_out (res_q)
  );

  assign trailer = TRAIL_W'(trailer_for(res_step(int'(res_q), data, MOD), TRAIL_W, MOD));

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    trl_d   = trl_q;
    data_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DATA;
          cnt_d   = '0;
          data_d  = in_data[DATA_W-1];
          shreg_d = in_data << 1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_DATA) begin
          state_d = TRAIL;
          cnt_d   = FIRST_TRAIL;
          data_d  = trailer[TRAIL_W-1];
          trl_d   = trailer << 1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          data_d  = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
        end
      end
      TRAIL: begin
        if (cnt_q == LAST_TRAIL) begin
          if (accept) begin
            state_d = DATA;
            cnt_d   = '0;
            data_d  = in_data[DATA_W-1];
            shreg_d = in_data << 1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          data_d = trl_q[TRAIL_W-1];
          trl_d  = trl_q << 1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags describe the bit that will sit on 'data' next cycle.
    vld_d = (state_d != IDLE);
    fs_d  = accept;
    fe_d  = (state_d == TRAIL) && (cnt_d == LAST_TRAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      trl_q       <= '0;
      data        <= 1'b0;
      data_vld    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      trl_q       <= trl_d;
      data        <= data_d;
      data_vld    <= vld_d;
      frame_start <= fs_d;
      frame_end   <= fe_d;
    end
  end

`ifdef SEQ_MOD3_GEN_SELFCHK_EN
  // Independent tracker over every emitted bit, trailer included. The last
  // bit is folded in combinationally at frame_end so a back-to-back clear
  // on the same edge does not hide it.
  logic [RES_W-1:0] chk_res;

  seq_mod_residue #(
    .MOD   (MOD),
    .RES_W (RES_W)
  ) u_chk_res (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (data_vld),
    .bit_in  (data),
    .res_out (chk_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= frame_end && (res_step(int'(chk_res), data, MOD) != 0);
    end
  end
`endif

endmodule

// File: tb/tb_seq_mod3_generator.sv
// ---------------------------------------------------------------------------
// tb_seq_mod3_generator
// Scoreboard bench: each accepted word pushes its ten expected frame bits
// (payload MSB-first, hand-computed trailer, start/end flags); a monitor on
// the falling edge pops and compares whenever data_vld is high, and also
// confirms every completed frame is 0 mod 3.
// ---------------------------------------------------------------------------
module tb_seq_mod3_generator;

  typedef struct packed {
    logic d;
    logic fs;
    logic fe;
  } exp_t;

  typedef struct packed {
    logic [7:0] w;
    logic [1:0] trl;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       data;
  logic       data_vld;
  logic       frame_start;
  logic       frame_end;
`ifdef SEQ_MOD3_GEN_SELFCHK_EN
  logic       chk_err;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   acc = 0;
  bit   chk_due = 1'b0;

  always #5 clk = ~clk;

  seq_mod3_generator #(
    .DATA_W  (8),
    .MOD     (3),
    .TRAIL_W (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .data        (data),
    .data_vld    (data_vld),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef SEQ_MOD3_GEN_SELFCHK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] w, input logic [1:0] trl);
    logic [9:0] f;
    f = {w, trl};
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{d: f[9-i], fs: (i == 0), fe: (i == 9)});
    end
  endtask

  // Offers a word and waits (bounded) for the cycle in which it is taken.
  // Returns just after the accepting edge, with bit 0 now on 'data'.
  task automatic send_word(input logic [7:0] w, input logic [1:0] trl, input bit release_valid);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        push_frame(w, trl);
      end
      @(posedge clk);
      #1;
    end
    if (release_valid) in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Monitor: compare every frame bit against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
`ifdef SEQ_MOD3_GEN_SELFCHK_EN
      if (chk_due) check("chk_err", 32'(chk_err), 32'd0);
`endif
      if (data_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_bit", 32'(data_vld), 32'd0);
        end else begin
          e = sb.pop_front();
          check("data", 32'(data), 32'(e.d));
          check("frame_start", 32'(frame_start), 32'(e.fs));
          check("frame_end", 32'(frame_end), 32'(e.fe));
          acc = frame_start ? int'(data) : (acc * 2 + int'(data));
          if (frame_end) check("frame_mod3", 32'(acc % 3), 32'd0);
        end
      end else begin
        check("idle_outputs", 32'({data, frame_start, frame_end}), 32'd0);
      end
      chk_due = data_vld && frame_end;
    end else begin
      chk_due = 1'b0;
    end
  end

  vec_t vecs[6] = '{
    '{w: 8'h05, trl: 2'b01},   // 21
    '{w: 8'h01, trl: 2'b10},   // 6
    '{w: 8'h02, trl: 2'b01},   // 9
    '{w: 8'hFF, trl: 2'b00},   // 1020
    '{w: 8'h80, trl: 2'b01},   // 513
    '{w: 8'h07, trl: 2'b10}    // 30
  };

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state.
    #12;
    check("rst_data", 32'(data), 32'd0);
    check("rst_data_vld", 32'(data_vld), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_end", 32'(frame_end), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed words with hand-computed trailers.
    foreach (vecs[i]) begin
      send_word(vecs[i].w, vecs[i].trl, 1'b1);
    end
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back with in_valid held: 20 contiguous bits, one ready slot.
    send_word(8'hA5, 2'b00, 1'b0);
    in_data = 8'h3C;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check("b2b_data_vld", 32'(data_vld), 32'd1);
      if (c < 20) check("b2b_in_ready", 32'(in_ready), 32'(c == 10));
      if (c == 10) push_frame(8'h3C, 2'b00);
      @(posedge clk);
      #1;
      if (c == 10) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_gap_after", 32'(data_vld), 32'd0);
    @(posedge clk);
    #1;

    // in_valid toggling while busy must be ignored.
    send_word(8'h01, 2'b10, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      in_valid = c[0];
      in_data  = 8'hFF;
      @(negedge clk);
      check("busy_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("no_second_frame", 32'(data_vld), 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset while payload bit 4 is on the line.
    send_word(8'h5A, 2'b00, 1'b1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_data", 32'(data), 32'd0);
    check("abort_data_vld", 32'(data_vld), 32'd0);
    check("abort_frame_start", 32'(frame_start), 32'd0);
    check("abort_frame_end", 32'(frame_end), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(8'h05, 2'b01, 1'b1);

`ifdef SEQ_MOD3_GEN_SELFCHK_EN
    // Random words; trailer from the arithmetic definition of the frame.
    for (int n = 0; n < 500; n++) begin
      logic [7:0] w;
      int         rs;
      w  = 8'($urandom_range(0, 255));
      rs = ((int'(w) % 3) * 4) % 3;
      send_word(w, 2'((3 - rs) % 3), 1'b1);
    end
`endif

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
